// File: rtl/fsic_io_tx_framer.sv
// Core-clock transmit framer feeding the io_serdes serializer: link bring-up FSM,
// 2-entry payload buffer and one data/idle/training frame word per coreclk.
module fsic_io_tx_framer #(
  parameter  int pCLK_RATIO    = 4,
  parameter  int pNUM_LANE     = 12,
  parameter  int pTRAIN_CYCLES = 16,
  localparam int FW            = pCLK_RATIO * pNUM_LANE
) (
  input  logic          coreclk,
  input  logic          axis_rst_n,
  input  logic          txen,
  input  logic          peer_rx_locked,
  input  logic          tx_hold,
  input  logic [FW-3:0] in_tdata,
  input  logic          in_tvalid,
  output logic          in_tready,
  output logic [FW-1:0] tx_frame,
  output logic [1:0]    link_state,
  output logic [15:0]   tx_data_cnt
);

  typedef enum logic [1:0] {
    ST_OFF    = 2'd0,
    ST_TRAIN  = 2'd1,
    ST_ACTIVE = 2'd2
  } state_t;

  localparam logic [1:0] HDR_DATA  = 2'b01;
  localparam logic [1:0] HDR_IDLE  = 2'b10;
  localparam logic [1:0] HDR_TRAIN = 2'b11;
  localparam logic [7:0] TRAIN_LAST = 8'(pTRAIN_CYCLES - 1);

  // 1010 pattern anchored to absolute frame bit positions (odd bits set).
  localparam int                  PAT_REPS = (FW + 3) / 4;
  localparam logic [4*PAT_REPS-1:0] PAT_FULL = {PAT_REPS{4'b1010}};

  state_t          r_state;
  logic [7:0]      r_train_cnt;
  logic [FW-3:0]   r_mem [2];
  logic            r_wr_ptr;
  logic            r_rd_ptr;
  logic [1:0]      r_count;

  state_t          w_state_nxt;
  logic [7:0]      w_train_nxt;
  logic [FW-1:0]   w_frame_nxt;
  logic            w_pop;
  logic            w_push;

  assign in_tready  = (r_count < 2'd2) && axis_rst_n;
  assign w_push     = in_tvalid && in_tready;
  assign link_state = r_state;

  // NOTE: every variable gets a default before the case so no path leaves it unassigned (no latches).
  always_comb begin
    w_state_nxt = r_state;
    w_train_nxt = r_train_cnt;
    w_frame_nxt = '0;
    w_pop       = 1'b0;
    unique case (r_state)
      ST_OFF: begin
        if (txen) begin
          w_state_nxt = ST_TRAIN;
          w_train_nxt = '0;
        end
      end
      ST_TRAIN: begin
        w_frame_nxt = {HDR_TRAIN, PAT_FULL[FW-3:8], r_train_cnt};
        if (r_train_cnt != 8'hFF) w_train_nxt = r_train_cnt + 8'd1;
        if (!txen)
          w_state_nxt = ST_OFF;
        else if (r_train_cnt >= TRAIN_LAST && peer_rx_locked)
          w_state_nxt = ST_ACTIVE;
      end
      ST_ACTIVE: begin
        if (r_count != 2'd0 && !tx_hold) begin
          w_pop       = 1'b1;
          w_frame_nxt = {HDR_DATA, r_mem[r_rd_ptr]};
        end else begin
          w_frame_nxt = {HDR_IDLE, {(FW-2){1'b0}}};
        end
        // The frame of an exit cycle still follows ACTIVE; the buffer is kept.
        if (!txen) begin
          w_state_nxt = ST_OFF;
        end else if (!peer_rx_locked) begin
          w_state_nxt = ST_TRAIN;
          w_train_nxt = '0;
        end
      end
      default: w_state_nxt = ST_OFF;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers sample the same edge.
  always_ff @(posedge coreclk or negedge axis_rst_n) begin
    if (!axis_rst_n) begin
      r_state     <= ST_OFF;
      r_train_cnt <= '0;
      tx_frame    <= '0;
      tx_data_cnt <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_train_cnt <= w_train_nxt;
      tx_frame    <= w_frame_nxt;
      if (w_pop) tx_data_cnt <= tx_data_cnt + 16'd1;
    end
  end

  // NOTE: the two buffer entries are reset too, so a reset leaves no stale payload behind.
  always_ff @(posedge coreclk or negedge axis_rst_n) begin
    if (!axis_rst_n) begin
      r_mem[0] <= '0;
      r_mem[1] <= '0;
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= in_tdata;
        r_wr_ptr        <= ~r_wr_ptr;
      end
      if (w_pop) r_rd_ptr <= ~r_rd_ptr;
      unique case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: tb/tb_fsic_io_tx_framer.sv
// Directed bench for fsic_io_tx_framer: bring-up, streaming, hold, relock,
// training saturation, data-counter wrap and asynchronous reset.
module tb_fsic_io_tx_framer;

  localparam int FW = 48;
  localparam logic [47:0] TRAIN0 = 48'hEAAA_AAAA_AA00;
  localparam logic [47:0] IDLE   = 48'h8000_0000_0000;
  localparam logic [47:0] DATA0  = 48'h4000_0000_0000;

  logic          coreclk = 1'b0;
  logic          axis_rst_n;
  logic          txen, peer_rx_locked, tx_hold, in_tvalid, in_tready;
  logic [FW-3:0] in_tdata;
  logic [FW-1:0] tx_frame;
  logic [1:0]    link_state;
  logic [15:0]   tx_data_cnt;

  int n_checks = 0;
  int n_errors = 0;

  fsic_io_tx_framer dut (
    .coreclk        (coreclk),
    .axis_rst_n     (axis_rst_n),
    .txen           (txen),
    .peer_rx_locked (peer_rx_locked),
    .tx_hold        (tx_hold),
    .in_tdata       (in_tdata),
    .in_tvalid      (in_tvalid),
    .in_tready      (in_tready),
    .tx_frame       (tx_frame),
    .link_state     (link_state),
    .tx_data_cnt    (tx_data_cnt)
  );

  always #5 coreclk = ~coreclk;

  task automatic check(input string tag, input logic [47:0] got, input logic [47:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%012h expected 0x%012h", tag, got, exp);
    end
  endtask

  // One rising edge; outputs are sampled at the following falling edge.
  task automatic tick();
    @(negedge coreclk);
  endtask

  initial begin
    int bad;
    axis_rst_n = 1'b0; txen = 1'b1; peer_rx_locked = 1'b1; tx_hold = 1'b0;
    in_tvalid = 1'b0; in_tdata = '0;
    tick(); tick();
    check("rst_frame", tx_frame, 48'h0);
    check("rst_state", link_state, 48'd0);
    check("rst_cnt",   tx_data_cnt, 48'd0);
    check("rst_ready", in_tready, 48'd0);

    // 1: bring-up with the peer locked from the start
    axis_rst_n = 1'b1;
    tick();
    check("off_to_train", link_state, 48'd1);
    check("off_frame", tx_frame, 48'h0);
    for (int i = 0; i < 16; i++) begin
      tick();
      check($sformatf("train%0d", i), tx_frame, TRAIN0 | 48'(i));
      check($sformatf("train_st%0d", i), link_state, (i == 15) ? 48'd2 : 48'd1);
    end
    tick();
    check("idle1", tx_frame, IDLE);
    check("ready_active", in_tready, 48'd1);

    // 2: three back-to-back payloads
    in_tvalid = 1'b1; in_tdata = 46'h1;
    tick(); check("t2_idle", tx_frame, IDLE);
    in_tdata = 46'h2;
    tick(); check("t2_d1", tx_frame, DATA0 | 48'h1); check("t2_rdy1", in_tready, 48'd1);
    in_tdata = 46'h3;
    tick(); check("t2_d2", tx_frame, DATA0 | 48'h2); check("t2_rdy2", in_tready, 48'd1);
    in_tvalid = 1'b0;
    tick(); check("t2_d3", tx_frame, DATA0 | 48'h3);
    tick(); check("t2_idle2", tx_frame, IDLE);
    check("t2_cnt", tx_data_cnt, 48'd3);

    // 3: hold fills the buffer, release drains it in order
    tx_hold = 1'b1; in_tvalid = 1'b1; in_tdata = 46'hA;
    tick(); check("t3_idle_a", tx_frame, IDLE);
    in_tdata = 46'hB;
    tick(); check("t3_idle_b", tx_frame, IDLE); check("t3_full", in_tready, 48'd0);
    tick(); check("t3_idle_c", tx_frame, IDLE); check("t3_full2", in_tready, 48'd0);
    in_tvalid = 1'b0; tx_hold = 1'b0;
    tick(); check("t3_da", tx_frame, DATA0 | 48'hA); check("t3_rdy", in_tready, 48'd1);
    tick(); check("t3_db", tx_frame, DATA0 | 48'hB);
    tick(); check("t3_idle_d", tx_frame, IDLE);
    check("t3_cnt", tx_data_cnt, 48'd5);

    // 4: lock loss with one buffered entry, entry survives retraining
    tx_hold = 1'b1; in_tvalid = 1'b1; in_tdata = 46'hC;
    tick(); in_tvalid = 1'b0;
    check("t4_hold_idle", tx_frame, IDLE);
    peer_rx_locked = 1'b0;
    tick(); check("t4_exit_idle", tx_frame, IDLE); check("t4_st_train", link_state, 48'd1);
    tx_hold = 1'b0;
    tick(); check("t4_train0", tx_frame, TRAIN0);
    peer_rx_locked = 1'b1;
    for (int i = 1; i < 16; i++) begin
      tick();
      check($sformatf("t4_train%0d", i), tx_frame, TRAIN0 | 48'(i));
    end
    check("t4_st_active", link_state, 48'd2);
    tick(); check("t4_dc", tx_frame, DATA0 | 48'hC);
    check("t4_cnt", tx_data_cnt, 48'd6);

    // 5: lock held low, counter saturates; then txen off
    peer_rx_locked = 1'b0;
    tick(); check("t5_exit_idle", tx_frame, IDLE);
    for (int j = 1; j <= 300; j++) begin
      tick();
      if (j == 1 || j == 20 || j == 256 || j == 300)
        check($sformatf("t5_train_j%0d", j), tx_frame, TRAIN0 | 48'((j - 1 > 255) ? 255 : j - 1));
    end
    check("t5_st", link_state, 48'd1);
    txen = 1'b0;
    tick(); check("t5_last_train", tx_frame, TRAIN0 | 48'hFF); check("t5_off", link_state, 48'd0);
    tick(); check("t5_off_frame", tx_frame, 48'h0);

    // 6: re-enable, stream to 0xFFFF, wrap, then async reset mid-stream
    txen = 1'b1; peer_rx_locked = 1'b1;
    tick();
    for (int i = 0; i < 16; i++) tick();
    check("t6_active", link_state, 48'd2);
    bad = 0;
    in_tvalid = 1'b1;
    for (int j = 1; j <= 65529; j++) begin
      in_tdata = 46'(j - 1);
      tick();
      if (j >= 2 && tx_frame !== (DATA0 | 48'(j - 2))) bad++;
      if (in_tready !== 1'b1) bad++;
    end
    check("t6_stream_bad", 48'(bad), 48'd0);
    in_tvalid = 1'b0;
    tick(); check("t6_last", tx_frame, DATA0 | 48'(65528));
    check("t6_cnt_ffff", tx_data_cnt, 48'hFFFF);
    in_tvalid = 1'b1; in_tdata = 46'h3FFF_FFFF_FFFF;
    tick(); in_tvalid = 1'b0;
    tick(); check("t6_maxpay", tx_frame, 48'h7FFF_FFFF_FFFF);
    check("t6_wrap", tx_data_cnt, 48'h0);
    in_tvalid = 1'b1; in_tdata = 46'h5;
    tick(); tick();
    check("t6_pre_rst", tx_frame, DATA0 | 48'h5);
    #2 axis_rst_n = 1'b0;
    #1;
    check("t6_rst_frame", tx_frame, 48'h0);
    check("t6_rst_state", link_state, 48'd0);
    check("t6_rst_cnt", tx_data_cnt, 48'd0);
    check("t6_rst_ready", in_tready, 48'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/fsic_io_tx_framer.md
Name: fsic_io_tx_framer

Overview:
- Core-clock-domain transmit framer directly upstream of the io_serdes serializer.
- Accepts a valid/ready payload stream and emits exactly one frame word per coreclk: data, idle or link training.
- The ioclk-side serializer slices each frame into pCLK_RATIO lane beats using the coreclk phase count.
- Owns link bring-up (training until the peer reports lock), a 2-entry input buffer, and idle insertion.

Parameters:
- pCLK_RATIO, 4, ioclk cycles per coreclk; beats per frame.
- pNUM_LANE, 12, serial lanes. Frame width FW = pCLK_RATIO*pNUM_LANE (48).
- pTRAIN_CYCLES, 16, minimum training frames before ACTIVE is allowed (range 2..255).

Ports:
- coreclk  in  1  frame clock.
- axis_rst_n  in  1  reset.
- txen  in  1  link enable, synchronous to coreclk.
- peer_rx_locked  in  1  peer receiver aligned, already synchronised to coreclk.
- tx_hold  in  1  force idle frames while ACTIVE (flow pause).
- in_tdata  in  FW-2  payload.
- in_tvalid  in  1  payload valid.
- in_tready  out  1  buffer can accept.
- tx_frame  out  FW  frame word to serializer; [FW-1:FW-2] header, [FW-3:0] body.
- link_state  out  2  0 OFF, 1 TRAIN, 2 ACTIVE.
- tx_data_cnt  out  16  data frames sent, wraps.

Behaviour:
- Reset: axis_rst_n is asynchronous, active-low; clock coreclk. All registers clear on reset.
  - tx_frame=0, link_state=OFF, tx_data_cnt=0, buffer empty, train counter=0, in_tready=0.
- Headers:
  - 2'b01 data: body = payload.
  - 2'b10 idle: body = 0.
  - 2'b11 training: body = {repeating 4'b1010 pattern, 8-bit train counter} in low bits.
  - 2'b00 is emitted only in OFF.
- FSM, registered, evaluated every coreclk:
  - OFF: tx_frame=0. If txen=1, go to TRAIN and clear the train counter.
  - TRAIN: emit a training frame each cycle; the train counter increments and saturates at 255.
    - Go to ACTIVE when train counter >= pTRAIN_CYCLES-1 and peer_rx_locked=1.
    - txen=0 -> OFF.
  - ACTIVE: emit a data frame if the buffer is non-empty and tx_hold=0; otherwise emit an idle frame.
    - peer_rx_locked=0 -> TRAIN (counter cleared).
    - txen=0 -> OFF.
    - On any exit, the frame in that cycle follows the current state; buffered data is retained, not dropped.
- Buffer: 2-entry FIFO.
  - in_tready = (count<2) && axis_rst_n, combinational from the registered count.
  - Push when in_tvalid && in_tready.
  - Pop only when a data frame is registered in ACTIVE.
  - Simultaneous push and pop: count unchanged, FIFO order preserved.
  - When full, in_tready=0 even in a pop cycle.
- Latency: a beat pushed at edge k into an empty buffer, in ACTIVE with hold low, appears on tx_frame after edge k+1. No bubbles in sustained streaming with in_tvalid held high.
- tx_frame is a registered output, updated every coreclk edge. tx_data_cnt increments per data frame and wraps 0xFFFF->0.
- Reset mid-operation clears the buffer; any in-flight payload is lost.

Test Plan:
1. Reset release, txen=1, peer_rx_locked=1 from start -> frames 0..15 have header 2'b11 with counter 0..15; ACTIVE on edge 16; idle frames (0x8000_0000_0000 for FW=48) while no input.
2. ACTIVE, push payloads 0x1,0x2,0x3 on consecutive cycles -> tx_frame = 0x4000_0000_0001, then ..0002, then ..0003 on consecutive cycles starting one cycle after the first push; tx_data_cnt=3; in_tready stays 1.
3. tx_hold=1 with in_tvalid held -> two pushes accepted, in_tready=0, idle frames emitted. Release hold -> both drain in order.
4. peer_rx_locked deasserted with 1 buffered entry in ACTIVE -> TRAIN next cycle, counter restarts at 0, entry kept. Relock after 16 frames -> entry sent first.
5. peer_rx_locked held 0 -> TRAIN persists past pTRAIN_CYCLES with the counter saturating at 255; txen=0 -> OFF, tx_frame=0.
6. Preload tx_data_cnt to 0xFFFF by sending 65535 frames, then send 1 more -> counter wraps to 0. Async reset mid-stream -> all outputs at reset values immediately.
